sram_port_arbiter: RTL

Shares one single-ported, fixed-latency SRAM between the IF stage (instruction read) and the MEM stage (load/store) of the ARM pipeline. It grants one requester at a time and holds the SRAM command stable for the full access. It returns read data with a one-cycle ready pulse, and the pipeline freezes on the deasserted ready. A taken branch can squash an in-flight instruction fetch.

---
 rtl/sram_port_arbiter_pkg.sv | 24 ++
 rtl/sram_port_arbiter_wait_counter.sv | 34 +++
 rtl/sram_port_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   state_t   : arbiter FSM encoding (IDLE / BUSY / RESP)
//   OWN_IF    : owner code for the instruction-fetch requester
//   OWN_MEM   : owner code for the load/store requester
//   cnt_width : bits needed to hold a counter value 0..max_val (min 1)
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_wait_counter.sv
// Loadable down-counter timing how long the SRAM command is held.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   load     : load LOAD_VAL (takes priority over dec)
//   dec      : decrement by one; saturates at zero
//   zero     : count is zero
module wait_counter
  import sram_port_arbiter_pkg::*;
#(
  parameter int LOAD_VAL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int W = cnt_width(LOAD_VAL);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= W'(LOAD_VAL);
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported fixed-latency SRAM between instruction fetch (IF)
// and load/store (MEM). One requester is granted at a time; the SRAM command
// is held stable for SRAM_LATENCY cycles, then the owner's ready pulses once.
//   if_*        : fetch request/address in, ready pulse and registered data out
//   mem_*       : load/store request, we, address, wdata in; ready, data out
//   branch_flush_in : squashes an in-flight fetch (access still completes)
//   sram_*      : SRAM command out, read data in
//   state_dbg   : current FSM state, for observation only
//
// Handshake: req is a level held with its address/data until the matching
// ready pulse. Request fields are sampled only at grant (in IDLE); requests
// present during RESP are ignored, and a request still high in the next
// IDLE cycle counts as a new request.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int SRAM_LATENCY = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_ready_out,
  output logic [DATA_W-1:0] if_rdata_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_wdata_in,
  output logic              mem_ready_out,
  output logic [DATA_W-1:0] mem_rdata_out,
  input  logic              branch_flush_in,
  output logic              sram_en_out,
  output logic              sram_we_out,
  output logic [ADDR_W-1:0] sram_addr_out,
  output logic [DATA_W-1:0] sram_wdata_out,
  input  logic [DATA_W-1:0] sram_rdata_in,
  output logic [1:0]        state_dbg
);

  localparam int CNT_LOAD = SRAM_LATENCY - 1;

  state_t            state;
  state_t            state_nxt;
  logic              owner_q;
  logic              prio_q;
  logic              kill_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] if_hold_q;
  logic [DATA_W-1:0] mem_rdata_q;

  logic              grant;
  logic              grant_owner;
  logic [ADDR_W-1:0] grant_addr;
  logic              cnt_zero;
  logic              last_busy;
  logic              flush_if;

  // Both requesting: the pointer decides. Single requester: it wins.
  assign grant       = (state == ST_IDLE) && (if_req_in || mem_req_in);
  assign grant_owner = (if_req_in && mem_req_in) ? prio_q : mem_req_in;
  assign grant_addr  = (grant_owner == OWN_MEM) ? mem_addr_in : if_addr_in;
  assign last_busy   = (state == ST_BUSY) && cnt_zero;
  assign flush_if    = branch_flush_in && (owner_q == OWN_IF);

  wait_counter #(
    .LOAD_VAL (CNT_LOAD)
  ) u_wait_counter (
    .clk  (clk),
    .rst  (rst),
    .load (grant),
    .dec  (state == ST_BUSY),
    .zero (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant) state_nxt = ST_BUSY;
      ST_BUSY: if (cnt_zero) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner_q     <= OWN_IF;
      prio_q      <= OWN_MEM;
      kill_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      if_hold_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state <= state_nxt;

      if (grant) begin
        owner_q <= grant_owner;
        prio_q  <= ~grant_owner;
        addr_q  <= grant_addr & ~ADDR_W'(3);
        we_q    <= (grant_owner == OWN_MEM) && mem_we_in;
        wdata_q <= (grant_owner == OWN_MEM) ? mem_wdata_in : '0;
      end

      // Kill lives for the rest of the access and drops as we return to IDLE.
      if ((state == ST_BUSY) && flush_if) begin
        kill_q <= 1'b1;
      end else if (state == ST_RESP) begin
        kill_q <= 1'b0;
      end

      if (last_busy) begin
        if ((owner_q == OWN_MEM) && !we_q) begin
          mem_rdata_q <= sram_rdata_in;
        end
        if (owner_q == OWN_IF) begin
          if_hold_q <= if_rdata_q;
          if (!kill_q && !branch_flush_in) begin
            if_rdata_q <= sram_rdata_in;
          end
        end
      end

      // A flush arriving in RESP squashes a fetch whose data was already
      // captured; put the previous instruction back.
      if ((state == ST_RESP) && flush_if && !kill_q) begin
        if_rdata_q <= if_hold_q;
      end
    end
  end

  assign sram_en_out    = (state == ST_BUSY);
  assign sram_we_out    = (state == ST_BUSY) && we_q;
  assign sram_addr_out  = (state == ST_BUSY) ? addr_q : '0;
  assign sram_wdata_out = (state == ST_BUSY) ? wdata_q : '0;

  assign mem_ready_out = (state == ST_RESP) && (owner_q == OWN_MEM);
  assign if_ready_out  = (state == ST_RESP) && (owner_q == OWN_IF) &&
                         !kill_q && !branch_flush_in;

  assign if_rdata_out  = if_rdata_q;
  assign mem_rdata_out = mem_rdata_q;
  assign state_dbg     = state;

endmodule
